// File: rtl/mux_scan.sv
// mux_scan: N-channel registered multiplexer with manual channel load,
// round-robin scan with programmable dwell, sample-and-hold freeze and
// status pulses for channel change, wrap-around and illegal selection.
module mux_scan #(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2,
    parameter int DWELL    = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CHANNELS*WIDTH-1:0] data_in,
    input  logic                      mode,
    input  logic                      sel_load,
    input  logic [SEL_W-1:0]          sel_in,
    input  logic                      hold,
    output logic [WIDTH-1:0]          s,
    output logic [SEL_W-1:0]          ch,
    output logic                      ch_change,
    output logic                      wrap,
    output logic                      err
);

    // A one-bit counter still works for DWELL of 1 or 2.
    localparam int                CNT_W    = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int                NCODES   = 2 ** SEL_W;
    localparam logic [SEL_W:0]    CH_LIMIT = (SEL_W + 1)'(CHANNELS);
    localparam logic [SEL_W-1:0]  CH_LAST  = SEL_W'(CHANNELS - 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DWELL - 1);

    // Unpacked view of the input channels; unused index codes read as zero
    // so the mux is fully defined even though ch never reaches them.
    logic [WIDTH-1:0] chan [NCODES];

    generate
        for (genvar gi = 0; gi < NCODES; gi++) begin : g_chan
            if (gi < CHANNELS) begin : g_used
                assign chan[gi] = data_in[gi*WIDTH +: WIDTH];
            end else begin : g_unused
                assign chan[gi] = '0;
            end
        end
    endgenerate

    logic [WIDTH-1:0] s_q, s_d;
    logic [SEL_W-1:0] ch_q, ch_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mode_q, mode_d;
    logic             chg_q, chg_d;
    logic             wrap_q, wrap_d;
    logic             err_q, err_d;

    logic sel_valid;
    logic mode_flip;
    logic at_last;

    // Next-state selection: valid load beats hold, hold beats scan advance.
    always_comb begin
        s_d       = s_q;
        ch_d      = ch_q;
        cnt_d     = cnt_q;
        mode_d    = mode;
        chg_d     = 1'b0;
        wrap_d    = 1'b0;
        sel_valid = sel_load && ({1'b0, sel_in} < CH_LIMIT);
        mode_flip = (mode != mode_q);
        at_last   = (cnt_q == CNT_LAST);
        // An illegal index is flagged but otherwise ignored.
        err_d     = sel_load && !sel_valid;

        // Output register samples the channel selected before this edge.
        if (!hold) begin
            s_d = chan[ch_q];
        end

        if (sel_valid) begin
            ch_d  = sel_in;
            cnt_d = '0;
            chg_d = (sel_in != ch_q);
        end else if (mode_flip) begin
            // A mode switch restarts the dwell count without moving ch.
            cnt_d = '0;
        end else if (hold) begin
            cnt_d = cnt_q;
        end else if (!mode) begin
            cnt_d = '0;
        end else if (at_last) begin
            cnt_d  = '0;
            ch_d   = (ch_q == CH_LAST) ? '0 : ch_q + 1'b1;
            chg_d  = 1'b1;
            wrap_d = (ch_q == CH_LAST);
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // State register; mode is tracked during reset so a scan held across
    // reset restarts with a full dwell on channel 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            s_q    <= '0;
            ch_q   <= '0;
            cnt_q  <= '0;
            mode_q <= mode;
            chg_q  <= 1'b0;
            wrap_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            s_q    <= s_d;
            ch_q   <= ch_d;
            cnt_q  <= cnt_d;
            mode_q <= mode_d;
            chg_q  <= chg_d;
            wrap_q <= wrap_d;
            err_q  <= err_d;
        end
    end

    assign s         = s_q;
    assign ch        = ch_q;
    assign ch_change = chg_q;
    assign wrap      = wrap_q;
    assign err       = err_q;

endmodule

// File: tb/tb_mux_scan.sv
// Bench for mux_scan: a 4-channel and a 3-channel instance share one
// stimulus stream; a behavioural model predicts both every cycle and
// directed literal checks pin the model at the interesting points.
module tb_mux_scan;
    localparam int W  = 4;
    localparam int SW = 2;
    localparam int DW = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset, mode, sel_load, hold;
    logic [SW-1:0] sel_in;
    logic [4*W-1:0] din_a;
    logic [3*W-1:0] din_b;
    assign din_b = din_a[3*W-1:0];

    logic [W-1:0]  s_a, s_b;
    logic [SW-1:0] ch_a, ch_b;
    logic          chg_a, chg_b, wrap_a, wrap_b, err_a, err_b;

    mux_scan #(.WIDTH(W), .CHANNELS(4), .SEL_W(SW), .DWELL(DW)) dut_a (
        .clk(clk), .reset(reset), .data_in(din_a), .mode(mode),
        .sel_load(sel_load), .sel_in(sel_in), .hold(hold),
        .s(s_a), .ch(ch_a), .ch_change(chg_a), .wrap(wrap_a), .err(err_a)
    );

    mux_scan #(.WIDTH(W), .CHANNELS(3), .SEL_W(SW), .DWELL(DW)) dut_b (
        .clk(clk), .reset(reset), .data_in(din_b), .mode(mode),
        .sel_load(sel_load), .sel_in(sel_in), .hold(hold),
        .s(s_b), .ch(ch_b), .ch_change(chg_b), .wrap(wrap_b), .err(err_b)
    );

    int vectors = 0;
    int miscompares = 0;

    // Model state per instance (0 = 4 channels, 1 = 3 channels).
    int m_s[2], m_ch[2], m_cnt[2], m_chg[2], m_wrap[2], m_err[2], m_modep[2];
    int nch[2] = '{4, 3};
    bit m_valid = 1'b0;
    int oc;
    bit vld;

    task automatic cmp(input string name, input logic [31:0] act, input int exp);
        vectors++;
        if (act !== 32'(exp)) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Behavioural model: apply the selection rules to the inputs seen at each edge.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (reset) begin
                m_s[d] = 0; m_ch[d] = 0; m_cnt[d] = 0;
                m_chg[d] = 0; m_wrap[d] = 0; m_err[d] = 0;
                m_modep[d] = int'(mode);
            end else begin
                oc  = m_ch[d];
                vld = sel_load && (int'(sel_in) < nch[d]);
                m_err[d]  = int'(sel_load && !vld);
                m_chg[d]  = 0;
                m_wrap[d] = 0;
                if (!hold) m_s[d] = int'(din_a[oc*W +: W]);
                if (vld) begin
                    m_ch[d]  = int'(sel_in);
                    m_cnt[d] = 0;
                    m_chg[d] = int'(m_ch[d] != oc);
                end else if (int'(mode) != m_modep[d]) begin
                    m_cnt[d] = 0;
                end else if (hold) begin
                    m_cnt[d] = m_cnt[d];
                end else if (!mode) begin
                    m_cnt[d] = 0;
                end else if (m_cnt[d] == DW - 1) begin
                    m_cnt[d]  = 0;
                    m_ch[d]   = (oc + 1) % nch[d];
                    m_chg[d]  = 1;
                    m_wrap[d] = int'(oc == nch[d] - 1);
                end else begin
                    m_cnt[d] = m_cnt[d] + 1;
                end
                m_modep[d] = int'(mode);
            end
        end
        if (reset) m_valid = 1'b1;
    end

    // Compare both instances against the model once per cycle.
    always @(negedge clk) begin
        if (m_valid) begin
            cmp("a_s",    32'(s_a),    m_s[0]);
            cmp("a_ch",   32'(ch_a),   m_ch[0]);
            cmp("a_chg",  32'(chg_a),  m_chg[0]);
            cmp("a_wrap", 32'(wrap_a), m_wrap[0]);
            cmp("a_err",  32'(err_a),  m_err[0]);
            cmp("b_s",    32'(s_b),    m_s[1]);
            cmp("b_ch",   32'(ch_b),   m_ch[1]);
            cmp("b_chg",  32'(chg_b),  m_chg[1]);
            cmp("b_wrap", 32'(wrap_b), m_wrap[1]);
            cmp("b_err",  32'(err_b),  m_err[1]);
        end
    end

    // Advance until instance A's model reaches the given channel/count.
    task automatic wait_model(input int c, input int n, input string name);
        bit found;
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            if (m_ch[0] == c && m_cnt[0] == n) found = 1'b1;
            else tick();
        end
        if (!found) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: state ch=%0d cnt=%0d never reached", name, c, n);
        end
    endtask

    int seq[13] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0};
    logic [W-1:0] held_s;

    initial begin
        reset = 1'b1; mode = 1'b0; sel_load = 1'b0; sel_in = '0; hold = 1'b0;
        din_a = 16'hDCBA;
        repeat (3) tick();
        cmp("rst_s",    32'(s_a),    0);
        cmp("rst_ch",   32'(ch_a),   0);
        cmp("rst_chg",  32'(chg_a),  0);
        cmp("rst_wrap", 32'(wrap_a), 0);
        cmp("rst_err",  32'(err_a),  0);

        // Manual load of channel 2.
        reset = 1'b0;
        tick();
        cmp("man_s0", 32'(s_a), 32'hA);
        sel_load = 1'b1; sel_in = 2'd2;
        tick();
        sel_load = 1'b0;
        cmp("man_ch",  32'(ch_a),  2);
        cmp("man_chg", 32'(chg_a), 1);
        tick();
        cmp("man_s",    32'(s_a),   32'hC);
        cmp("man_chg0", 32'(chg_a), 0);

        // Illegal index on the 3-channel instance, legal on the 4-channel one.
        sel_load = 1'b1; sel_in = 2'd3;
        tick();
        sel_load = 1'b0;
        cmp("ill_err",  32'(err_b), 1);
        cmp("ill_ch",   32'(ch_b),  2);
        cmp("ill_chg",  32'(chg_b), 0);
        cmp("ill_a_ch", 32'(ch_a),  3);
        tick();
        cmp("ill_err0", 32'(err_b), 0);

        // Scan from channel 0.
        sel_load = 1'b1; sel_in = 2'd0;
        tick();
        sel_load = 1'b0;
        mode = 1'b1;
        for (int i = 0; i < 13; i++) begin
            tick();
            cmp("scan_ch",   32'(ch_a),   seq[i]);
            cmp("scan_chg",  32'(chg_a),  int'(i > 0 && i % 3 == 0));
            cmp("scan_wrap", 32'(wrap_a), int'(i == 12));
        end

        // Hold at the advance point of channel 1 while data changes.
        wait_model(1, DW - 1, "hold_wait");
        held_s = s_a;
        hold = 1'b1;
        tick();
        din_a = 16'h5678;
        for (int i = 0; i < 4; i++) begin
            tick();
            cmp("hold_ch",  32'(ch_a),  1);
            cmp("hold_s",   32'(s_a),   int'(held_s));
            cmp("hold_chg", 32'(chg_a), 0);
        end
        hold = 1'b0;
        tick();
        cmp("rel_ch",  32'(ch_a),  2);
        cmp("rel_chg", 32'(chg_a), 1);
        cmp("rel_s",   32'(s_a),   32'h7);

        // Load of channel 0 on the same edge as the 3->0 advance.
        wait_model(3, DW - 1, "pri_wait");
        sel_load = 1'b1; sel_in = 2'd0;
        tick();
        sel_load = 1'b0;
        cmp("pri_ch",   32'(ch_a),   0);
        cmp("pri_wrap", 32'(wrap_a), 0);
        cmp("pri_chg",  32'(chg_a),  1);
        tick();
        cmp("pri_d1", 32'(ch_a), 0);
        tick();
        cmp("pri_d2", 32'(ch_a), 0);
        tick();
        cmp("pri_d3", 32'(ch_a), 1);

        // Reset mid-scan with load and hold also asserted.
        wait_model(2, 1, "rst_wait");
        reset = 1'b1; sel_load = 1'b1; sel_in = 2'd1; hold = 1'b1;
        tick();
        reset = 1'b0; sel_load = 1'b0; hold = 1'b0;
        cmp("mrst_ch",   32'(ch_a),   0);
        cmp("mrst_s",    32'(s_a),    0);
        cmp("mrst_chg",  32'(chg_a),  0);
        cmp("mrst_wrap", 32'(wrap_a), 0);
        cmp("mrst_err",  32'(err_a),  0);
        tick();
        cmp("mrst_d1", 32'(ch_a), 0);
        cmp("mrst_s1", 32'(s_a),  32'h8);
        tick();
        cmp("mrst_d2", 32'(ch_a), 0);
        tick();
        cmp("mrst_d3",   32'(ch_a),  1);
        cmp("mrst_chg3", 32'(chg_a), 1);

        // Back to manual: counter parks, ch stays put.
        mode = 1'b0;
        repeat (5) tick();
        cmp("man_park", 32'(ch_a), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
